network_mul_rnd_sat_pipe: RTL and testbench

- Parametrised successor to the fixed 16s×12s→28 single-cycle multiplier.
- Computes a signed full-precision product, then applies a configurable right-shift with optional round-half-up and optional saturation to a narrower output.
- Fully pipelined: NUM_STAGE register stages, clock enable, valid flag travelling with the data.
- Sits inside the network convolution datapath between the weight×activation product and the accumulator, replacing the separate multiply/shift/clip steps.

---
 rtl/network_mul_pkg.sv | 23 ++
 rtl/network_mul_round_sat.sv | 40 ++++
 rtl/network_mul_rnd_sat_pipe.sv | 109 ++++++++++
 tb/tb_network_mul_rnd_sat_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/network_mul_pkg.sv
// Shared constants and helper functions for the pipelined multiply/round/saturate datapath.
// Saturation and rounding work at a fixed 64-bit signed width wide enough for any legal product.
package network_mul_pkg;

  localparam int unsigned NUM_STAGE_MAX = 8;
  localparam int unsigned CALC_WIDTH    = 64;

  function automatic logic signed [CALC_WIDTH-1:0] sat_limit_hi(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [CALC_WIDTH-1:0] sat_limit_lo(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Half-LSB of the shifted result; zero when rounding is off or nothing is shifted out.
  function automatic logic signed [CALC_WIDTH-1:0] round_const(input int unsigned shift,
                                                               input int unsigned round);
    if (round != 0 && shift > 0) return 64'sd1 <<< (shift - 1);
    return 64'sd0;
  endfunction

endpackage

// File: rtl/network_mul_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturate/wrap of a signed product.
module network_mul_round_sat
  import network_mul_pkg::*;
#(
  parameter int unsigned prod_WIDTH = 28,
  parameter int unsigned dout_WIDTH = 16,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned ROUND      = 1,
  parameter int unsigned SATURATE   = 1
) (
  input  logic signed [prod_WIDTH-1:0] prod,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         dout_sat
);

  localparam logic signed [CALC_WIDTH-1:0] RND_K  = round_const(SHIFT, ROUND);
  localparam logic signed [CALC_WIDTH-1:0] LIM_HI = sat_limit_hi(dout_WIDTH);
  localparam logic signed [CALC_WIDTH-1:0] LIM_LO = sat_limit_lo(dout_WIDTH);

  logic signed [CALC_WIDTH-1:0] prod_ext;
  logic signed [CALC_WIDTH-1:0] shifted;
  logic                         ovf_hi;
  logic                         ovf_lo;

  // Evaluating wider than the product keeps the rounding add from overflowing.
  assign prod_ext = {{(CALC_WIDTH - prod_WIDTH){prod[prod_WIDTH-1]}}, prod};
  assign shifted  = (prod_ext + RND_K) >>> SHIFT;
  assign ovf_hi   = shifted > LIM_HI;
  assign ovf_lo   = shifted < LIM_LO;

  always_comb begin
    dout     = shifted[dout_WIDTH-1:0];
    dout_sat = ovf_hi | ovf_lo;
    if (SATURATE != 0) begin
      if (ovf_hi)      dout = LIM_HI[dout_WIDTH-1:0];
      else if (ovf_lo) dout = LIM_LO[dout_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/network_mul_rnd_sat_pipe.sv
// Pipelined signed multiplier with rounding shift and optional saturation; NUM_STAGE ce-cycles
// of latency with a valid flag travelling alongside the data.
module network_mul_rnd_sat_pipe
  import network_mul_pkg::*;
#(
  parameter int unsigned ID         = 1,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned din0_WIDTH = 16,
  parameter int unsigned din1_WIDTH = 12,
  parameter int unsigned dout_WIDTH = 16,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned ROUND      = 1,
  parameter int unsigned SATURATE   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         din_vld,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         dout_vld,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         dout_sat
);

  localparam int unsigned W = din0_WIDTH + din1_WIDTH;

  logic signed [din0_WIDTH-1:0] op_a;
  logic signed [din1_WIDTH-1:0] op_b;
  logic signed [W-1:0]          prod_comb;
  logic signed [W-1:0]          prod_rs;
  logic signed [dout_WIDTH-1:0] rs_dout;
  logic                         rs_sat;
  logic signed [dout_WIDTH-1:0] dout_q;
  logic                         sat_q;
  logic [NUM_STAGE-1:0]         vld_q;

  assign prod_comb = $signed({{din1_WIDTH{op_a[din0_WIDTH-1]}}, op_a})
                   * $signed({{din0_WIDTH{op_b[din1_WIDTH-1]}}, op_b});

  if (NUM_STAGE == 1) begin : g_no_op_reg
    assign op_a    = din0;
    assign op_b    = din1;
    assign prod_rs = prod_comb;
  end else begin : g_op_reg
    logic signed [din0_WIDTH-1:0] a_q;
    logic signed [din1_WIDTH-1:0] b_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_q <= '0;
        b_q <= '0;
      end else if (ce) begin
        a_q <= din0;
        b_q <= din1;
      end
    end

    assign op_a = a_q;
    assign op_b = b_q;

    if (NUM_STAGE == 2) begin : g_no_prod_reg
      assign prod_rs = prod_comb;
    end else begin : g_prod_reg
      logic signed [W-1:0] prod_q [NUM_STAGE-2];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < int'(NUM_STAGE) - 2; i++) prod_q[i] <= '0;
        end else if (ce) begin
          prod_q[0] <= prod_comb;
          for (int i = 1; i < int'(NUM_STAGE) - 2; i++) prod_q[i] <= prod_q[i-1];
        end
      end

      assign prod_rs = prod_q[NUM_STAGE-3];
    end
  end

  network_mul_round_sat #(
    .prod_WIDTH (W),
    .dout_WIDTH (dout_WIDTH),
    .SHIFT      (SHIFT),
    .ROUND      (ROUND),
    .SATURATE   (SATURATE)
  ) u_round_sat (
    .prod     (prod_rs),
    .dout     (rs_dout),
    .dout_sat (rs_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
      sat_q  <= 1'b0;
      vld_q  <= '0;
    end else if (ce) begin
      dout_q   <= rs_dout;
      sat_q    <= rs_sat;
      vld_q[0] <= din_vld;
      for (int i = 1; i < int'(NUM_STAGE); i++) vld_q[i] <= vld_q[i-1];
    end
  end

  assign dout     = dout_q;
  assign dout_sat = sat_q;
  assign dout_vld = vld_q[NUM_STAGE-1];

endmodule

// File: tb/tb_network_mul_rnd_sat_pipe.sv
// Directed and reference-model checks of network_mul_rnd_sat_pipe across several configurations.
module tb_network_mul_rnd_sat_pipe;

  logic clk = 1'b0;
  logic reset, ce, din_vld;
  logic signed [15:0] din0;
  logic signed [11:0] din1;

  logic vld_d, vld_w, vld_1, vld_2, vld_8;
  logic sat_d, sat_w, sat_1, sat_2, sat_8;
  logic signed [15:0] dout_d, dout_w, dout_1, dout_2, dout_8;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  network_mul_rnd_sat_pipe u_dflt (
    .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
    .dout_vld(vld_d), .dout(dout_d), .dout_sat(sat_d));

  network_mul_rnd_sat_pipe #(.SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
    .dout_vld(vld_w), .dout(dout_w), .dout_sat(sat_w));

  network_mul_rnd_sat_pipe #(.NUM_STAGE(1), .SHIFT(0)) u_s1 (
    .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
    .dout_vld(vld_1), .dout(dout_1), .dout_sat(sat_1));

  network_mul_rnd_sat_pipe #(.NUM_STAGE(2), .SHIFT(0)) u_s2 (
    .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
    .dout_vld(vld_2), .dout(dout_2), .dout_sat(sat_2));

  network_mul_rnd_sat_pipe #(.NUM_STAGE(8), .SHIFT(0)) u_s8 (
    .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
    .dout_vld(vld_8), .dout(dout_8), .dout_sat(sat_8));

  typedef struct {
    longint a;
    longint b;
    longint exp_dout;
    bit     exp_sat;
    longint exp_wdout;
    bit     exp_wsat;
  } vec_t;

  typedef struct {
    longint a;
    longint b;
    int     t;
  } inflight_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact product, optional half-up rounding, floor shift, clip or wrap to 16 bits.
  function automatic void model(input longint a, input longint b, input int shift,
                                input bit rnd, input bit sat, output longint d, output bit s);
    longint p, r;
    logic signed [15:0] low;
    p = a * b;
    if (rnd && shift > 0) p = p + (longint'(1) << (shift - 1));
    r = p >>> shift;
    s = (r > 32767) || (r < -32768);
    low = r[15:0];
    if (sat && r > 32767) d = 32767;
    else if (sat && r < -32768) d = -32768;
    else d = low;
  endfunction

  task automatic chk_inst(input string nm, input int ns, input int k, input longint sa[20],
                          input longint sb[20], input logic v, input logic signed [15:0] d,
                          input logic s);
    longint ed;
    bit es;
    int idx;
    idx = k - ns;
    if (idx >= 0 && idx < 20) begin
      model(sa[idx], sb[idx], 0, 1'b1, 1'b1, ed, es);
      chk({nm, " vld"}, longint'(v), 1);
      chk({nm, " dout"}, longint'(d), ed);
      chk({nm, " sat"}, longint'(s), longint'(es));
    end else begin
      chk({nm, " idle vld"}, longint'(v), 0);
    end
  endtask

  initial begin
    vec_t vecs[9];
    inflight_t q[$];
    inflight_t e;
    longint sa[20], sb[20];
    longint ed, pd;
    bit es, pv;
    int cecnt, sent, ai, bi;
    bit ce_now;

    vecs[0] = '{1000, 100, 391, 0, 391, 0};
    vecs[1] = '{-1000, 100, -391, 0, -391, 0};
    vecs[2] = '{-3, 128, -1, 0, -1, 0};
    vecs[3] = '{32767, 2047, 32767, 1, -136, 1};
    vecs[4] = '{-32768, 2047, -32768, 1, 128, 1};
    vecs[5] = '{-32768, -2048, 32767, 1, 0, 1};
    vecs[6] = '{32767, 256, 32767, 0, 32767, 0};
    vecs[7] = '{-32768, 256, -32768, 0, -32768, 0};
    vecs[8] = '{128, 257, 129, 0, 129, 0};

    reset = 1'b0; ce = 1'b0; din_vld = 1'b0; din0 = '0; din1 = '0;
    #1 reset = 1'b1;
    #1;
    chk("reset vld", longint'(vld_d), 0);
    chk("reset dout", longint'(dout_d), 0);
    chk("reset sat", longint'(sat_d), 0);
    tick();
    tick();
    reset = 1'b0;
    ce = 1'b1;
    tick();
    chk("post-reset vld", longint'(vld_d), 0);

    // Single isolated samples: latency exactly 3 and hand-computed values.
    for (int i = 0; i < 9; i++) begin
      din0 = 16'(vecs[i].a); din1 = 12'(vecs[i].b); din_vld = 1'b1;
      tick();
      din_vld = 1'b0;
      tick();
      chk($sformatf("vec%0d early vld", i), longint'(vld_d), 0);
      tick();
      chk($sformatf("vec%0d vld", i), longint'(vld_d), 1);
      chk($sformatf("vec%0d dout", i), longint'(dout_d), vecs[i].exp_dout);
      chk($sformatf("vec%0d sat", i), longint'(sat_d), longint'(vecs[i].exp_sat));
      chk($sformatf("vec%0d wrap dout", i), longint'(dout_w), vecs[i].exp_wdout);
      chk($sformatf("vec%0d wrap sat", i), longint'(sat_w), longint'(vecs[i].exp_wsat));
      tick();
      chk($sformatf("vec%0d vld drop", i), longint'(vld_d), 0);
    end

    // Back-to-back stream with ce stalls on cycles 2 and 5.
    cecnt = 0; sent = 0;
    pd = dout_d; pv = vld_d;
    for (int cyc = 0; cyc < 40 && (sent < 10 || q.size() > 0); cyc++) begin
      ce_now = !(cyc == 2 || cyc == 5);
      ce = ce_now;
      din_vld = (sent < 10);
      din0 = 16'(150 * (sent + 1) - 700);
      din1 = 12'(37 * sent - 100);
      if (ce_now && sent < 10) begin
        q.push_back('{longint'(150 * (sent + 1) - 700), longint'(37 * sent - 100), cecnt});
        sent++;
      end
      tick();
      if (ce_now) cecnt++;
      if (!ce_now) begin
        chk($sformatf("stall%0d dout hold", cyc), longint'(dout_d), pd);
        chk($sformatf("stall%0d vld hold", cyc), longint'(vld_d), longint'(pv));
      end else if (vld_d) begin
        if (q.size() == 0) begin
          chk("stream extra output", 1, 0);
        end else begin
          e = q.pop_front();
          model(e.a, e.b, 8, 1'b1, 1'b1, ed, es);
          chk($sformatf("stream dout c%0d", cyc), longint'(dout_d), ed);
          chk($sformatf("stream lat c%0d", cyc), longint'(cecnt - e.t), 3);
        end
      end
      pd = dout_d; pv = vld_d;
    end
    chk("stream all sent", longint'(sent), 10);
    chk("stream drained", longint'(q.size()), 0);
    ce = 1'b1; din_vld = 1'b0;

    // Reset with three samples in flight.
    for (int i = 0; i < 3; i++) begin
      din0 = 16'(1000 + i); din1 = 12'(100); din_vld = 1'b1;
      tick();
    end
    din_vld = 1'b0;
    chk("inflight vld", longint'(vld_d), 1);
    chk("inflight dout", longint'(dout_d), 391);
    reset = 1'b1;
    #1;
    chk("async rst vld", longint'(vld_d), 0);
    chk("async rst dout", longint'(dout_d), 0);
    chk("async rst sat", longint'(sat_d), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("no stale %0d", i), longint'(vld_d), 0);
    end
    din0 = 16'(-1000); din1 = 12'(100); din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    tick();
    chk("after rst early vld", longint'(vld_d), 0);
    tick();
    chk("after rst vld", longint'(vld_d), 1);
    chk("after rst dout", longint'(dout_d), -391);

    // Drain every pipeline, then sweep NUM_STAGE 1/2/8 at SHIFT=0.
    for (int i = 0; i < 10; i++) tick();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        ai = int'($urandom_range(0, 400)) - 200;
        bi = int'($urandom_range(0, 400)) - 200;
      end else begin
        ai = int'($urandom_range(0, 65535)) - 32768;
        bi = int'($urandom_range(0, 4095)) - 2048;
      end
      sa[i] = ai; sb[i] = bi;
    end
    for (int k = 1; k <= 29; k++) begin
      if (k - 1 < 20) begin
        din0 = 16'(sa[k-1]); din1 = 12'(sb[k-1]); din_vld = 1'b1;
      end else begin
        din_vld = 1'b0;
      end
      tick();
      chk_inst("ns1", 1, k, sa, sb, vld_1, dout_1, sat_1);
      chk_inst("ns2", 2, k, sa, sb, vld_2, dout_2, sat_2);
      chk_inst("ns8", 8, k, sa, sb, vld_8, dout_8, sat_8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
